mem_write_arbiter: RTL and testbench
====================================

# mem_write_arbiter

Sequencer and two-way arbiter in front of the single-port write memory (DATA_WIDTH × 2**ADDR_WIDTH words, write port addr/data/WR). After reset it clears every memory word to zero. It then shares the memory's single write port between two requesters using valid/ready handshakes and round-robin arbitration. It is the only block that drives the memory's write interface.

## Interface
- DATA_WIDTH, 64: word width; must match the memory.
- ADDR_WIDTH, 3: address width; depth N = 2**ADDR_WIDTH.

Reset is synchronous and active-low.

- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 has a write pending.
- req0_addr  in  ADDR_WIDTH  requester 0 target address.
- req0_data  in  DATA_WIDTH  requester 0 write data.
- req0_ready  out  1  requester 0 write accepted this cycle.
- req1_valid, req1_addr, req1_data, req1_ready: same as requester 0, for requester 1.
- init_done  out  1  clear sequence finished; arbitration enabled.
- mem_addr  out  ADDR_WIDTH  to memory addrIn; registered.
- mem_data  out  DATA_WIDTH  to memory dataIn; registered.
- mem_wr  out  1  to memory WR; registered.
- mem_src  out  1  source of the current mem_wr: 0/1 = requester, held 0 during clear; registered.

## Operation
- Reset values (rst_n low at an edge): state CLEAR, clear counter 0, last_grant 1 (requester 0 has priority first), mem_wr 0, mem_addr 0, mem_data 0, mem_src 0, init_done 0.
- Both readies are 0 while rst_n is low and while in CLEAR.
- CLEAR state:
  - Each cycle, register mem_wr=1, mem_addr=counter, mem_data=0.
  - Counter increments by 1.
  - When the counter reaches N-1, that write is issued and the next state is RUN.
  - The counter is ADDR_WIDTH+1 bits wide so the terminal compare does not wrap.
- RUN state: init_done=1. Arbitration is combinational from the valids and last_grant:
  - Only one valid: that requester is granted.
  - Both valid: the requester ≠ last_grant is granted.
  - Neither valid: no grant; last_grant unchanged.
  - reqX_ready = (state==RUN) & grantX. At most one ready is high per cycle.
- Transfer: valid & ready at a posedge.
  - On transfer, register mem_wr=1, mem_addr/mem_data from the winner, mem_src=winner, last_grant=winner.
  - With no transfer, mem_wr=0; mem_addr/mem_data/mem_src hold their values.
- Requester rules:
  - A requester must hold valid/addr/data stable until ready.
  - ready may depend on valid combinationally; valid must not depend on ready.
- Same-address writes from both requesters are serialized in grant order; the later grant wins in memory.
- Reset asserted mid-CLEAR or mid-RUN: an in-flight registered write is dropped (mem_wr 0 the next cycle) and CLEAR restarts from address 0.
- RUN is terminal until reset.

## Timing
- Clear sequence:
  - Reset released at edge E0.
  - mem_wr is high for exactly N consecutive cycles, the first visible after E0+1, with addresses 0..N-1 ascending.
  - init_done rises the same cycle the last clear write is visible on the memory port; first ready possible that cycle.
  - Total: N+1 edges from release to first acceptance.
- Write latency: handshake at edge T → mem_wr/addr/data valid after T → memory word updated at T+1.
- Throughput: one write per cycle. Under continuous contention the grant alternates 0,1,0,1…; each requester gets ≥1 grant per 2 cycles.
- No combinational path from inputs to mem_* outputs; the only combinational path is valid→ready.

## Structure
- Shared package/header mem_arb_pkg:
  - State encodings ST_CLEAR=1'b0, ST_RUN=1'b1.
  - Source IDs SRC_REQ0=0, SRC_REQ1=1.
  - Default DATA_WIDTH/ADDR_WIDTH constants shared with the memory.
- One sub-module, rr_arb2:
  - Inputs: req[1:0], last_grant. Output: one-hot grant[1:0].
  - Purely combinational.
  - last_grant register lives in the parent.
- Parent holds the FSM, the clear counter and the output registers.

## Test plan
- Reset release, N=8, no requests → mem_wr high 8 cycles, addr 0..7, data 0; init_done rises with addr 7; readies 0 throughout CLEAR.
- req0_valid held with addr 3, data 64'hDEAD_BEEF after init_done, req1 idle → req0_ready same cycle; next cycle mem_wr=1, mem_addr=3, mem_data=DEAD_BEEF, mem_src=0; memory word 3 reads DEAD_BEEF.
- Both valid continuously for 6 cycles from first RUN cycle → grants 0,1,0,1,0,1; mem_src follows the same sequence; never both readies high.
- Both write addr 5 (req0 data 1, req1 data 2) simultaneously, fresh after reset → req0 granted first, then req1; word 5 ends = 2.
- rst_n low for 1 cycle mid-RUN with a transfer at that edge → mem_wr 0 next cycle, init_done 0; clear restarts at addr 0 and runs 8 cycles.
- rst_n low at clear addr 4 → sequence restarts at 0, not 5; init_done only after a full 8-write clear.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory write arbiter: state and source encodings
// plus the default memory geometry shared with the write memory.
package mem_arb_pkg;

    localparam int MEM_DATA_WIDTH = 64;
    localparam int MEM_ADDR_WIDTH = 3;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam logic SRC_REQ0 = 1'b0;
    localparam logic SRC_REQ1 = 1'b1;

endpackage

// File: rtl/mem_write_arbiter_rr_arb2.sv
// Two-way round-robin grant logic; purely combinational, the last-grant
// history is held by the parent.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // One-hot grant: a lone requester wins, a tie goes to the one not granted last.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
                if (last_grant == SRC_REQ1) begin
                    grant = 2'b01;
                end else begin
                    grant = 2'b10;
                end
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_write_arbiter.sv
// Clears the write memory after reset, then shares its single write port
// between two valid/ready requesters with round-robin arbitration.
module mem_write_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_wr,
    output logic                  mem_src
);

    // One extra counter bit keeps the terminal compare clear of wrap-around.
    localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);

    state_e                state_r;
    state_e                state_nxt_s;
    logic [ADDR_WIDTH:0]   cnt_r;
    logic [ADDR_WIDTH:0]   cnt_nxt_s;
    logic                  last_grant_r;
    logic                  last_grant_nxt_s;
    logic                  init_done_r;
    logic                  init_done_nxt_s;
    logic                  mem_wr_r;
    logic                  mem_wr_nxt_s;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [ADDR_WIDTH-1:0] mem_addr_nxt_s;
    logic [DATA_WIDTH-1:0] mem_data_r;
    logic [DATA_WIDTH-1:0] mem_data_nxt_s;
    logic                  mem_src_r;
    logic                  mem_src_nxt_s;
    logic [1:0]            grant_s;
    logic                  run_s;

    rr_arb2 u_rr_arb2 (
        .req        ({req1_valid, req0_valid}),
        .last_grant (last_grant_r),
        .grant      (grant_s)
    );

    // Readies are gated by rst_n too, so nothing is accepted while reset is held.
    assign run_s      = (state_r == ST_RUN);
    assign req0_ready = rst_n & run_s & grant_s[0];
    assign req1_ready = rst_n & run_s & grant_s[1];

    assign init_done = init_done_r;
    assign mem_wr    = mem_wr_r;
    assign mem_addr  = mem_addr_r;
    assign mem_data  = mem_data_r;
    assign mem_src   = mem_src_r;

    // Next-state and next-output logic for the clear sequencer and the arbiter.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        last_grant_nxt_s = last_grant_r;
        init_done_nxt_s  = init_done_r;
        mem_wr_nxt_s     = 1'b0;
        mem_addr_nxt_s   = mem_addr_r;
        mem_data_nxt_s   = mem_data_r;
        mem_src_nxt_s    = mem_src_r;
        case (state_r)
            ST_CLEAR: begin
                mem_wr_nxt_s   = 1'b1;
                mem_addr_nxt_s = cnt_r[ADDR_WIDTH-1:0];
                mem_data_nxt_s = {DATA_WIDTH{1'b0}};
                mem_src_nxt_s  = SRC_REQ0;
                cnt_nxt_s      = cnt_r + CNT_ONE;
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s     = ST_RUN;
                    init_done_nxt_s = 1'b1;
                end else begin
                    state_nxt_s     = ST_CLEAR;
                    init_done_nxt_s = 1'b0;
                end
            end
            ST_RUN: begin
                init_done_nxt_s = 1'b1;
                if (grant_s[0]) begin
                    mem_wr_nxt_s     = 1'b1;
                    mem_addr_nxt_s   = req0_addr;
                    mem_data_nxt_s   = req0_data;
                    mem_src_nxt_s    = SRC_REQ0;
                    last_grant_nxt_s = SRC_REQ0;
                end else if (grant_s[1]) begin
                    mem_wr_nxt_s     = 1'b1;
                    mem_addr_nxt_s   = req1_addr;
                    mem_data_nxt_s   = req1_data;
                    mem_src_nxt_s    = SRC_REQ1;
                    last_grant_nxt_s = SRC_REQ1;
                end else begin
                    mem_wr_nxt_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_CLEAR;
            end
        endcase
    end

    // State, counter, grant history and memory-port registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_CLEAR;
            cnt_r        <= {(ADDR_WIDTH+1){1'b0}};
            last_grant_r <= SRC_REQ1;
            init_done_r  <= 1'b0;
            mem_wr_r     <= 1'b0;
            mem_addr_r   <= {ADDR_WIDTH{1'b0}};
            mem_data_r   <= {DATA_WIDTH{1'b0}};
            mem_src_r    <= SRC_REQ0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            init_done_r  <= init_done_nxt_s;
            mem_wr_r     <= mem_wr_nxt_s;
            mem_addr_r   <= mem_addr_nxt_s;
            mem_data_r   <= mem_data_nxt_s;
            mem_src_r    <= mem_src_nxt_s;
        end
    end

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Scoreboard bench for mem_write_arbiter: expected memory-port writes are
// queued as stimulus is applied and compared when the DUT presents them.
module tb_mem_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic [2:0]  req0_addr;
    logic [63:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [2:0]  req1_addr;
    logic [63:0] req1_data;
    logic        req1_ready;
    logic        init_done;
    logic [2:0]  mem_addr;
    logic [63:0] mem_data;
    logic        mem_wr;
    logic        mem_src;

    mem_write_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .init_done  (init_done),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_wr     (mem_wr),
        .mem_src    (mem_src)
    );

    typedef struct {
        logic [2:0]  addr;
        logic [63:0] data;
        logic        src;
    } wr_t;

    wr_t         sb_q[$];
    logic [63:0] mem_m [8];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        m_run = 1'b0;
    logic        m_last = 1'b1;
    int          m_cnt = 0;
    logic        acc0, acc1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory behind the write port.
    always @(posedge clk) begin
        if (mem_wr) mem_m[mem_addr] <= mem_data;
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input logic rst,
                        input logic v0, input logic [2:0] a0, input logic [63:0] d0,
                        input logic v1, input logic [2:0] a1, input logic [63:0] d1,
                        output logic g0, output logic g1);
        logic e0, e1;
        wr_t  w;
        @(negedge clk);
        rst_n = rst;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        #1;
        e0 = 1'b0;
        e1 = 1'b0;
        if (rst && m_run) begin
            if (v0 && v1) begin
                if (m_last) e0 = 1'b1;
                else        e1 = 1'b1;
            end else begin
                e0 = v0;
                e1 = v1;
            end
        end
        check_val("ready0", req0_ready, e0);
        check_val("ready1", req1_ready, e1);
        check_val("ready_excl", req0_ready & req1_ready, 1'b0);
        g0 = e0;
        g1 = e1;
        if (!rst) begin
            sb_q.delete();
            m_run = 1'b0;
            m_cnt = 0;
            m_last = 1'b1;
        end else if (!m_run) begin
            sb_q.push_back('{3'(m_cnt), 64'd0, 1'b0});
            if (m_cnt == 7) m_run = 1'b1;
            m_cnt++;
        end else if (e0) begin
            sb_q.push_back('{a0, d0, 1'b0});
            m_last = 1'b0;
        end else if (e1) begin
            sb_q.push_back('{a1, d1, 1'b1});
            m_last = 1'b1;
        end
        @(posedge clk);
        #1;
        check_val("init_done", init_done, m_run);
        if (sb_q.size() > 0) begin
            w = sb_q.pop_front();
            check_val("mem_wr", mem_wr, 1'b1);
            check_val("mem_addr", mem_addr, w.addr);
            check_val("mem_data", mem_data, w.data);
            check_val("mem_src", mem_src, w.src);
        end else begin
            check_val("mem_wr_idle", mem_wr, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        logic x0, x1;
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'd0, 64'd0, 1'b0, 3'd0, 64'd0, x0, x1);
    endtask

    task automatic do_reset();
        logic x0, x1;
        step(1'b0, 1'b0, 3'd0, 64'd0, 1'b0, 3'd0, 64'd0, x0, x1);
    endtask

    initial begin
        logic [2:0]  p0a, p1a;
        logic [63:0] p0d, p1d;
        bit          done1;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_addr = 3'd0; req0_data = 64'd0;
        req1_valid = 1'b0; req1_addr = 3'd0; req1_data = 64'd0;

        // Reset, clear sequence with req0 already waiting late in CLEAR.
        do_reset();
        do_reset();
        idle(5);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 3'd3, 64'hDEAD_BEEF, 1'b0, 3'd0, 64'd0, acc0, acc1);
        step(1'b1, 1'b1, 3'd3, 64'hDEAD_BEEF, 1'b0, 3'd0, 64'd0, acc0, acc1);
        check_val("req0_first_accept", acc0, 1'b1);
        idle(2);
        check_val("word3", mem_m[3], 64'hDEAD_BEEF);
        check_val("word0_cleared", mem_m[0], 64'd0);

        // Continuous contention from the first RUN cycle.
        do_reset();
        idle(8);
        p0a = 3'($urandom); p0d = {$urandom, $urandom};
        p1a = 3'($urandom); p1d = {$urandom, $urandom};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, p0a, p0d, 1'b1, p1a, p1d, acc0, acc1);
            if (acc0) begin p0a = 3'($urandom); p0d = {$urandom, $urandom}; end
            if (acc1) begin p1a = 3'($urandom); p1d = {$urandom, $urandom}; end
        end
        idle(1);

        // Same-address collision fresh after reset: req0 then req1, req1 data wins.
        do_reset();
        idle(8);
        done1 = 1'b0;
        step(1'b1, 1'b1, 3'd5, 64'd1, 1'b1, 3'd5, 64'd2, acc0, acc1);
        for (int i = 0; i < 4 && !done1; i++) begin
            step(1'b1, 1'b0, 3'd0, 64'd0, 1'b1, 3'd5, 64'd2, acc0, acc1);
            done1 = acc1;
        end
        idle(2);
        check_val("word5", mem_m[5], 64'd2);

        // Reset mid-RUN with a request pending at that edge.
        step(1'b0, 1'b1, 3'd1, 64'h55, 1'b0, 3'd0, 64'd0, acc0, acc1);
        idle(8);
        idle(1);

        // Reset mid-CLEAR at address 4; clear must restart at 0.
        do_reset();
        idle(4);
        do_reset();
        idle(8);
        idle(1);
        check_val("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
